baud_tick_gen: RTL
==================

// Module: baud_tick_gen
// PURPOSE
//  Programmable fractional baud tick generator, the successor to the fixed-rate UART baud clock.
//  Emits single-cycle enables (not a derived clock): os_tick at pOVERSAMPLE x baud for the RX
//  sampler, and bit_tick once per bit for TX.
//  Divisor is integer + fractional and can be reloaded at run time without glitching a period.
//  Sits between the sys_clk domain and both UART TX/RX FSMs.
// PARAMETERS
//  pSYS_CLK_FREQ  100000000  system clock frequency, Hz
//  pDEFAULT_BAUD  9600       baud rate used out of reset
//  pOVERSAMPLE    16         os_ticks per bit_tick (power of 2, >=2)
//  pDIV_WIDTH     16         width of the integer divisor D
//  pFRAC_WIDTH    4          width of the fractional divisor F (units of 1/2^pFRAC_WIDTH)
// PORTS
//  sys_clk     in   1              system clock, all logic on rising edge
//  Sync_rst    in   1              synchronous active-high reset
//  en          in   1              1 = run; 0 = hold and clear the period counter and phase
//  cfg_load    in   1              1-cycle strobe: capture cfg_div/cfg_frac
//  cfg_div     in   pDIV_WIDTH     new integer divisor D (sys_clk cycles per os_tick)
//  cfg_frac    in   pFRAC_WIDTH    new fractional divisor F
//  cfg_ack     out  1              1-cycle pulse: pending config now active
//  os_tick     out  1              1-cycle oversample enable
//  bit_tick    out  1              1-cycle bit enable, coincident with every pOVERSAMPLE-th os_tick
//  bit_phase   out  clog2(pOVERSAMPLE)  os_tick index within the current bit
//  div_active  out  pDIV_WIDTH     integer divisor currently in use
// BEHAVIOUR
//  - Reset: cnt=0, acc=0, carry=0, phase=0, pending=0. Outputs os_tick=0, bit_tick=0,
//    cfg_ack=0, bit_phase=0.
//  - Reset defaults: D0 = pSYS_CLK_FREQ/(pOVERSAMPLE*pDEFAULT_BAUD) (floor);
//    F0 = (pSYS_CLK_FREQ*2^pFRAC_WIDTH/(pOVERSAMPLE*pDEFAULT_BAUD)) mod 2^pFRAC_WIDTH.
//    div_active = D0 out of reset (651 and F0 = 0 at the default parameters).
//  - Period length: L = D + carry. cnt counts 0..L-1 on each edge with en=1.
//  - Period boundary (edge with cnt==L-1, en=1): cnt<=0; os_tick<=1 for one cycle;
//    {carry,acc} <= acc + F. carry sets the length of the NEXT period.
//  - Tick timing: with en held high from reset release, the first os_tick is high in cycle D
//    (cycle 1 = first enabled edge). Intervals for D=4, F=8 (pFRAC_WIDTH=4): 4,4,5,4,5,...
//  - Phase: at each boundary phase <= phase+1 mod pOVERSAMPLE.
//    bit_tick<=1 at a boundary where phase==pOVERSAMPLE-1. bit_phase mirrors phase.
//  - en=0: cnt, phase, acc and carry are cleared; os_tick=bit_tick=0. Restarting behaves as
//    fresh after reset, with the active divisor retained.
//  - cfg_load edge: shadow <= {cfg_div, cfg_frac}; pending<=1.
//    Loaded cfg_div<2 is clamped to 2.
//    A load while pending overwrites the shadow (last wins); only one ack is produced.
//  - Apply: at the first boundary strictly after the capture edge, or on the next edge if en=0.
//    Active <= shadow; acc, carry <= 0; pending <= 0; cfg_ack=1 in the following cycle.
//    The period in progress always completes at its old length. A load coincident with a
//    boundary applies at the next boundary.
//  - Sync_rst mid-operation: pending config is discarded, no ack, defaults restored.
//  - Widths: D0 must fit pDIV_WIDTH (elaboration $error otherwise).
//    acc wraps modulo 2^pFRAC_WIDTH.
// TESTING
//  1. Defaults, en=1 after reset -> os_tick first in cycle 651 then every 651;
//     bit_tick every 10416 cycles; bit_phase 0..15.
//  2. en=0, load D=4 F=8 -> cfg_ack 1 cycle after load; en=1 -> intervals 4,4,5,4,5,...;
//     first bit_tick in cycle 71.
//  3. Running D=4 F=0, load D=10 in mid-period -> current period ends at 4; next intervals 10;
//     cfg_ack 1 cycle after that boundary; div_active=10.
//  4. Two loads (D=6 then D=8) within one period -> one cfg_ack; div_active=8; intervals 8.
//  5. en dropped for 3 cycles mid-period, D=5 -> no ticks; bit_phase=0;
//     re-enable -> os_tick 5 cycles later.
//  6. Load cfg_div=0 -> div_active=2, os_tick every 2 cycles.
//     Sync_rst with a load pending -> no ack; div_active=651.

Source files
------------

// File: rtl/baud_tick_gen.sv
// Fractional baud tick generator: emits one-cycle os_tick/bit_tick enables from sys_clk using
// an integer + fractional divisor that can be reloaded at run time on a period boundary.
module baud_tick_gen #(
  parameter int pSYS_CLK_FREQ = 100000000,
  parameter int pDEFAULT_BAUD = 9600,
  parameter int pOVERSAMPLE   = 16,
  parameter int pDIV_WIDTH    = 16,
  parameter int pFRAC_WIDTH   = 4
) (
  input  logic                           sys_clk,
  input  logic                           Sync_rst,
  input  logic                           en,
  input  logic                           cfg_load,
  input  logic [pDIV_WIDTH-1:0]          cfg_div,
  input  logic [pFRAC_WIDTH-1:0]         cfg_frac,
  output logic                           cfg_ack,
  output logic                           os_tick,
  output logic                           bit_tick,
  output logic [$clog2(pOVERSAMPLE)-1:0] bit_phase,
  output logic [pDIV_WIDTH-1:0]          div_active
);

  localparam int PW = $clog2(pOVERSAMPLE);
  localparam longint BAUD_DEN = longint'(pOVERSAMPLE) * longint'(pDEFAULT_BAUD);
  localparam longint D0_FULL  = longint'(pSYS_CLK_FREQ) / BAUD_DEN;
  localparam longint F0_FULL  = (longint'(pSYS_CLK_FREQ) << pFRAC_WIDTH) / BAUD_DEN;
  localparam logic [pDIV_WIDTH-1:0]  D0 = pDIV_WIDTH'(D0_FULL);
  localparam logic [pFRAC_WIDTH-1:0] F0 = pFRAC_WIDTH'(F0_FULL);
  localparam logic [PW-1:0] PHASE_LAST = PW'(pOVERSAMPLE - 1);

  if (D0_FULL >= (longint'(1) << pDIV_WIDTH)) begin : g_d0_check
    $error("baud_tick_gen: default divisor does not fit pDIV_WIDTH");
  end

  // Config handshake: cfg_load is a one-cycle strobe with no back-pressure. The last strobe
  // before the apply point wins, and cfg_ack pulses once when that shadow becomes active.
  logic [pDIV_WIDTH-1:0]  cnt_q, cnt_d;
  logic [pFRAC_WIDTH-1:0] acc_q, acc_d;
  logic                   carry_q, carry_d;
  logic [PW-1:0]          phase_q, phase_d;
  logic                   pending_q, pending_d;
  logic [pDIV_WIDTH-1:0]  shd_div_q, shd_div_d;
  logic [pFRAC_WIDTH-1:0] shd_frac_q, shd_frac_d;
  logic [pDIV_WIDTH-1:0]  div_q, div_d;
  logic [pFRAC_WIDTH-1:0] frac_q, frac_d;
  logic                   os_tick_q, os_tick_d;
  logic                   bit_tick_q, bit_tick_d;
  logic                   ack_q, ack_d;

  logic [pDIV_WIDTH:0] period_last;
  logic                boundary;
  logic                apply;

  always_comb begin
    period_last = {1'b0, div_q} + {{pDIV_WIDTH{1'b0}}, carry_q} - 1'b1;
    boundary    = en && ({1'b0, cnt_q} == period_last);
    apply       = pending_q && (boundary || !en);

    cnt_d      = cnt_q;
    acc_d      = acc_q;
    carry_d    = carry_q;
    phase_d    = phase_q;
    pending_d  = pending_q;
    shd_div_d  = shd_div_q;
    shd_frac_d = shd_frac_q;
    div_d      = div_q;
    frac_d     = frac_q;
    os_tick_d  = 1'b0;
    bit_tick_d = 1'b0;
    ack_d      = 1'b0;

    if (!en) begin
      cnt_d   = '0;
      acc_d   = '0;
      carry_d = 1'b0;
      phase_d = '0;
    end else if (boundary) begin
      cnt_d              = '0;
      os_tick_d          = 1'b1;
      bit_tick_d         = (phase_q == PHASE_LAST);
      phase_d            = phase_q + 1'b1;
      {carry_d, acc_d}   = {1'b0, acc_q} + {1'b0, frac_q};
    end else begin
      cnt_d = cnt_q + 1'b1;
    end

    // The new divisor restarts the fractional accumulation from zero.
    if (apply) begin
      div_d     = shd_div_q;
      frac_d    = shd_frac_q;
      acc_d     = '0;
      carry_d   = 1'b0;
      pending_d = 1'b0;
      ack_d     = 1'b1;
    end

    if (cfg_load) begin
      shd_div_d  = (cfg_div < pDIV_WIDTH'(2)) ? pDIV_WIDTH'(2) : cfg_div;
      shd_frac_d = cfg_frac;
      pending_d  = 1'b1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (Sync_rst) begin
      cnt_q      <= '0;
      acc_q      <= '0;
      carry_q    <= 1'b0;
      phase_q    <= '0;
      pending_q  <= 1'b0;
      shd_div_q  <= D0;
      shd_frac_q <= F0;
      div_q      <= D0;
      frac_q     <= F0;
      os_tick_q  <= 1'b0;
      bit_tick_q <= 1'b0;
      ack_q      <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      carry_q    <= carry_d;
      phase_q    <= phase_d;
      pending_q  <= pending_d;
      shd_div_q  <= shd_div_d;
      shd_frac_q <= shd_frac_d;
      div_q      <= div_d;
      frac_q     <= frac_d;
      os_tick_q  <= os_tick_d;
      bit_tick_q <= bit_tick_d;
      ack_q      <= ack_d;
    end
  end

  assign cfg_ack    = ack_q;
  assign os_tick    = os_tick_q;
  assign bit_tick   = bit_tick_q;
  assign bit_phase  = phase_q;
  assign div_active = div_q;

endmodule
